shot_clock_counter: RTL and testbench

- Shot-clock timebase and BCD down-counter. Generates a 0.1 s tick from the board clock and counts from 24.0 (or 14.0) down to 0.0.
- Drives the horn at expiry.
- Sits directly upstream of the per-digit hex/BCD-to-seven-segment decoders. The tens, ones and tenths outputs each feed one decoder instance unchanged.

---
 rtl/shot_clock_counter.sv | 123 ++++++++++++
 tb/tb_shot_clock_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/shot_clock_counter.sv
// Shot-clock timebase and BCD down-counter: 0.1 s prescaler, 24.0/14.0 reload,
// borrow-chain decrement to 0.0 and a timed horn at expiry.
module shot_clock_counter #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_DIV    = CLK_HZ / 10,
  parameter int HORN_TENTHS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       set_24,
  input  logic       set_14,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [3:0] tenths,
  output logic       low_time,
  output logic       running,
  output logic       horn
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int HW = (HORN_TENTHS < 1) ? 1 : $clog2(HORN_TENTHS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HORN_LOAD = HW'(HORN_TENTHS);
  localparam logic [HW-1:0] HORN_ONE  = HW'(1);

  typedef enum logic [1:0] {S_STOP, S_RUN, S_EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] htmr_q, htmr_d;
  logic [3:0]    tens_q, tens_d, ones_q, ones_d, tenths_q, tenths_d;
  logic          run_q, run_d, horn_q, horn_d;
  logic          tick, ge14, do_reload;

  // The prescaler only advances while counting or while the horn is timing out.
  assign tick      = ((state_q == S_RUN) || horn_q) && (cnt_q == CNT_MAX);
  assign ge14      = (tens_q == 4'd2) || ((tens_q == 4'd1) && (ones_q >= 4'd4));
  assign do_reload = set_24 || (set_14 && !ge14);

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    htmr_d   = htmr_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    tenths_d = tenths_q;
    horn_d   = horn_q;

    // Any effective command clears the prescaler and swallows a coincident tick.
    if (do_reload) begin
      tens_d   = set_24 ? 4'd2 : 4'd1;
      ones_d   = 4'd4;
      tenths_d = 4'd0;
      if (state_q == S_EXPIRED) begin
        state_d = S_STOP;
        horn_d  = 1'b0;
        htmr_d  = '0;
      end
    end else if (stop && (state_q == S_RUN)) begin
      state_d = S_STOP;
    end else if (start && (state_q == S_STOP)) begin
      state_d = S_RUN;
    end else begin
      if ((state_q == S_RUN) || horn_q)
        cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick && (state_q == S_RUN)) begin
        if ((tens_q == 4'd0) && (ones_q == 4'd0) && (tenths_q <= 4'd1)) begin
          tenths_d = 4'd0;
          state_d  = S_EXPIRED;
          horn_d   = (HORN_TENTHS != 0);
          htmr_d   = HORN_LOAD;
        end else if (tenths_q != 4'd0) begin
          tenths_d = tenths_q - 4'd1;
        end else begin
          tenths_d = 4'd9;
          if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end
        end
      end else if (tick && horn_q) begin
        htmr_d = htmr_q - HORN_ONE;
        if (htmr_q == HORN_ONE) horn_d = 1'b0;
      end
    end

    run_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_STOP;
      cnt_q    <= '0;
      htmr_q   <= '0;
      tens_q   <= 4'd2;
      ones_q   <= 4'd4;
      tenths_q <= 4'd0;
      run_q    <= 1'b0;
      horn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      htmr_q   <= htmr_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      tenths_q <= tenths_d;
      run_q    <= run_d;
      horn_q   <= horn_d;
    end
  end

  assign tens     = tens_q;
  assign ones     = ones_q;
  assign tenths   = tenths_q;
  assign running  = run_q;
  assign horn     = horn_q;
  assign low_time = (tens_q == 4'd0) && (ones_q < 4'd5);

endmodule

// File: tb/tb_shot_clock_counter.sv
// Directed bench for shot_clock_counter; an integer-tenths model is checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_shot_clock_counter;

  localparam int TD = 4;
  localparam int HT = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0, stop = 1'b0, set_24 = 1'b0, set_14 = 1'b0;
  logic [3:0] tens, ones, tenths;
  logic       low_time, running, horn;

  shot_clock_counter #(.CLK_HZ(40), .TICK_DIV(TD), .HORN_TENTHS(HT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .set_24(set_24), .set_14(set_14),
    .tens(tens), .ones(ones), .tenths(tenths),
    .low_time(low_time), .running(running), .horn(horn)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: remaining time in integer tenths, run/expired flags, horn ticks left.
  int m_t = 240, m_phase = 0, m_horn_left = 0;
  bit m_run = 1'b0, m_exp = 1'b0, m_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    if (reset) begin
      m_t = 240; m_run = 0; m_exp = 0; m_horn_left = 0; m_phase = 0;
    end else if (set_24 || (set_14 && m_t < 140)) begin
      m_t = set_24 ? 240 : 140;
      if (m_exp) begin m_exp = 0; m_horn_left = 0; end
      m_phase = 0;
    end else if (stop && m_run) begin
      m_run = 0; m_phase = 0;
    end else if (start && !m_run && !m_exp) begin
      m_run = 1; m_phase = 0;
    end else if (m_run || m_horn_left > 0) begin
      if (m_phase == TD - 1) begin
        m_phase = 0;
        if (m_run) begin
          if (m_t <= 1) begin
            m_t = 0; m_run = 0; m_exp = 1; m_horn_left = HT;
          end else begin
            m_t = m_t - 1;
          end
        end else begin
          m_horn_left = m_horn_left - 1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    logic [14:0] act_v, exp_v;
    @(negedge clk);
    if (m_valid) begin
      act_v = {tens, ones, tenths, running, horn, low_time};
      exp_v = {4'(m_t / 100), 4'((m_t / 10) % 10), 4'(m_t % 10),
               m_run, (m_horn_left > 0), (m_t < 50)};
      check("cycle {tens,ones,tenths,run,horn,low}", int'(act_v), int'(exp_v));
    end
    @(posedge clk);
    model_edge();
    m_valid = 1'b1;
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input bit s24, input bit s14, input bit stp, input bit sta);
    set_24 = s24; set_14 = s14; stop = stp; start = sta;
    step();
    set_24 = 0; set_14 = 0; stop = 0; start = 0;
  endtask

  task automatic run_to(input int target);
    int k;
    k = 0;
    while (m_t != target && k < 3000) begin
      step();
      k++;
    end
    if (m_t != target) begin
      n_checks++;
      $display("FAIL run_to timeout: model at %0d wanted %0d", m_t, target);
    end
  endtask

  task automatic check_lit(input string name, input int val, input bit run, input bit hrn);
    check({name, " value"}, int'(tens) * 100 + int'(ones) * 10 + int'(tenths), val);
    check({name, " running"}, int'(running), int'(run));
    check({name, " horn"}, int'(horn), int'(hrn));
  endtask

  initial begin
    reset = 1;
    wait_n(2);
    reset = 0;
    wait_n(100);
    check_lit("idle after reset", 240, 0, 0);
    check("idle low_time", int'(low_time), 0);

    pulse(0, 0, 0, 1);
    wait_n(3);
    check_lit("3 cycles after start", 240, 1, 0);
    wait_n(1);
    check_lit("first tick", 239, 1, 0);
    wait_n(12);
    check_lit("4 ticks", 236, 1, 0);

    run_to(50);
    check("low_time at 5.0", int'(low_time), 0);
    wait_n(4);
    check_lit("4.9", 49, 1, 0);
    check("low_time at 4.9", int'(low_time), 1);

    run_to(1);
    wait_n(4);
    check_lit("expiry", 0, 0, 1);
    wait_n(79);
    check_lit("horn last cycle", 0, 0, 1);
    wait_n(1);
    check_lit("horn off", 0, 0, 0);
    pulse(0, 0, 0, 1);
    wait_n(5);
    check_lit("start ignored expired", 0, 0, 0);

    pulse(1, 0, 0, 0);
    check_lit("set_24 from expired", 240, 0, 0);
    pulse(0, 0, 0, 1);
    run_to(183);
    pulse(0, 1, 0, 0);
    check_lit("set_14 at 18.3", 183, 1, 0);
    run_to(97);
    pulse(0, 1, 0, 0);
    check_lit("set_14 at 9.7", 140, 1, 0);

    run_to(125);
    pulse(0, 0, 1, 0);
    wait_n(50);
    check_lit("stopped 12.5", 125, 0, 0);
    pulse(0, 0, 0, 1);
    wait_n(3);
    check_lit("resume pending", 125, 1, 0);
    wait_n(1);
    check_lit("resume 12.4", 124, 1, 0);

    run_to(33);
    pulse(1, 0, 1, 0);
    check_lit("set_24+stop at 3.3", 240, 1, 0);

    run_to(1);
    wait_n(4);
    check_lit("second expiry", 0, 0, 1);
    wait_n(10);
    pulse(1, 0, 0, 0);
    check_lit("set_24 during horn", 240, 0, 0);
    wait_n(20);
    check_lit("held after horn cancel", 240, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
